// File: rtl/tpu_loader.sv
// Frame sequencer between a host word stream and a convolution engine: streams the
// kernel then the matrix into the engine and queues the engine results in a small FIFO.
module tpu_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int MATRIX_DIM = 32,
    parameter int CONV_DIM   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  tpu_rst,
    output logic                  tpu_insert_kernal,
    output logic                  tpu_write_mode,
    output logic                  tpu_write,
    output logic                  tpu_ready,
    output logic [DATA_WIDTH-1:0] tpu_data_in,
    input  logic                  tpu_done,
    input  logic [DATA_WIDTH-1:0] tpu_data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int KN  = CONV_DIM * CONV_DIM;
    localparam int MN  = MATRIX_DIM * MATRIX_DIM;
    localparam int WCW = $clog2((MN > KN) ? MN : KN) + 1;
    localparam int RCW = $clog2(MN) + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;

    localparam logic [WCW-1:0] K_LAST = WCW'(KN - 1);
    localparam logic [WCW-1:0] M_LAST = WCW'(MN - 1);
    localparam logic [WCW-1:0] W_ONE  = WCW'(1);
    localparam logic [RCW-1:0] R_LAST = RCW'(MN - 1);
    localparam logic [RCW-1:0] R_ONE  = RCW'(1);
    localparam logic [PW-1:0]  P_ONE  = PW'(1);
    localparam logic [PW-1:0]  P_FULL = PW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLR     = 3'd1;
    localparam logic [2:0] S_LOAD_K  = 3'd2;
    localparam logic [2:0] S_LOAD_M  = 3'd3;
    localparam logic [2:0] S_COMPUTE = 3'd4;
    localparam logic [2:0] S_FIN     = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [1:0]            r_rst_sync;
    logic [WCW-1:0]        r_word_cnt;
    logic [RCW-1:0]        r_res_cnt;
    logic                  r_overflow;
    logic                  r_frame_done;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;

    logic                  w_accept;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push_req;
    logic                  w_push;
    logic                  w_drop;
    logic [PW-1:0]         w_fifo_cnt;

    assign w_accept   = in_valid & in_ready;
    assign w_fifo_cnt = r_wr_ptr - r_rd_ptr;
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (w_fifo_cnt == P_FULL);
    assign w_pop      = ~w_empty & out_ready;
    assign w_push_req = (r_state == S_COMPUTE) & tpu_done;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & w_full & ~w_pop;

    assign out_valid  = ~w_empty;
    assign out_data   = r_mem[r_rd_ptr[AW-1:0]];
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

    // Release of rst_n is only trusted after two clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    // Engine pin and host handshake decode.
    always_comb begin
        in_ready          = 1'b0;
        tpu_rst           = 1'b0;
        tpu_insert_kernal = 1'b0;
        tpu_write_mode    = 1'b0;
        tpu_write         = 1'b0;
        tpu_ready         = 1'b0;
        tpu_data_in       = {DATA_WIDTH{1'b0}};
        case (r_state)
            S_CLR: begin
                tpu_rst = 1'b1;
            end
            S_LOAD_K: begin
                in_ready          = 1'b1;
                tpu_write_mode    = 1'b1;
                tpu_insert_kernal = 1'b1;
                tpu_write         = in_valid;
                tpu_ready         = in_valid;
                tpu_data_in       = in_data;
            end
            S_LOAD_M: begin
                in_ready       = 1'b1;
                tpu_write_mode = 1'b1;
                tpu_write      = in_valid;
                tpu_data_in    = in_data;
            end
            S_COMPUTE: begin
                tpu_ready = 1'b1;
            end
            default: begin
                tpu_rst = 1'b0;
            end
        endcase
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && r_rst_sync[1]) begin
                    w_state_nxt = S_CLR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLR: begin
                w_state_nxt = S_LOAD_K;
            end
            S_LOAD_K: begin
                if (w_accept && (r_word_cnt == K_LAST)) begin
                    w_state_nxt = S_LOAD_M;
                end else begin
                    w_state_nxt = S_LOAD_K;
                end
            end
            S_LOAD_M: begin
                if (w_accept && (r_word_cnt == M_LAST)) begin
                    w_state_nxt = S_COMPUTE;
                end else begin
                    w_state_nxt = S_LOAD_M;
                end
            end
            S_COMPUTE: begin
                if (tpu_done && (r_res_cnt == R_LAST)) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_state_nxt = S_COMPUTE;
                end
            end
            S_FIN: begin
                if (w_empty) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_FIN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and frame-completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= (r_state == S_FIN) & w_empty;
        end
    end

    // Word counter restarts at zero for the matrix phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= {WCW{1'b0}};
        end else begin
            case (r_state)
                S_CLR: begin
                    r_word_cnt <= {WCW{1'b0}};
                end
                S_LOAD_K: begin
                    if (w_accept && (r_word_cnt == K_LAST)) begin
                        r_word_cnt <= {WCW{1'b0}};
                    end else if (w_accept) begin
                        r_word_cnt <= r_word_cnt + W_ONE;
                    end else begin
                        r_word_cnt <= r_word_cnt;
                    end
                end
                S_LOAD_M: begin
                    if (w_accept && (r_word_cnt != M_LAST)) begin
                        r_word_cnt <= r_word_cnt + W_ONE;
                    end else begin
                        r_word_cnt <= r_word_cnt;
                    end
                end
                default: begin
                    r_word_cnt <= r_word_cnt;
                end
            endcase
        end
    end

    // Result counter counts dropped results too; overflow is sticky until CLR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_cnt  <= {RCW{1'b0}};
            r_overflow <= 1'b0;
        end else if (r_state == S_CLR) begin
            r_res_cnt  <= {RCW{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            if (w_push_req) begin
                r_res_cnt <= r_res_cnt + R_ONE;
            end else begin
                r_res_cnt <= r_res_cnt;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    // Result FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= tpu_data_out;
                r_wr_ptr                <= r_wr_ptr + P_ONE;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + P_ONE;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

endmodule

// File: doc/tpu_loader.md
TPU_LOADER -- requirements
Module: tpu_loader

Interface
REQ-001 The module SHALL take parameter DATA_WIDTH, default 8, the width of every data word.
REQ-002 The module SHALL take parameter MATRIX_DIM, default 32, the side length of the input matrix.
REQ-003 The module SHALL take parameter CONV_DIM, default 3, the side length of the kernel.
REQ-004 The module SHALL take parameter FIFO_DEPTH, default 4, the number of result FIFO entries (power of 2, at least 2).
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to begin a frame; sampled only in IDLE.
REQ-008 in_valid / in_ready / in_data  in / out / DATA_WIDTH  host word stream: kernel words first, then matrix words, row-major order.
REQ-009 tpu_rst, tpu_insert_kernal, tpu_write_mode, tpu_write, tpu_ready  out  1 each  drive the engine control pins of the same names.
REQ-010 tpu_data_in  out  DATA_WIDTH  drives the engine data_in pin.
REQ-011 tpu_done  in  1  engine done pulse.
REQ-012 tpu_data_out  in  DATA_WIDTH  engine accumulated sum.
REQ-013 out_valid / out_ready / out_data  out / in / DATA_WIDTH  result stream.
REQ-014 busy, frame_done, overflow  out  1 each  status outputs.

Function
REQ-015 States SHALL be IDLE, CLR, LOAD_K, LOAD_M, COMPUTE and FIN, encoded in a registered FSM.
REQ-016 IDLE SHALL go to CLR on start=1; in any other state, start SHALL be ignored.
REQ-017 CLR SHALL last exactly 1 cycle with tpu_rst=1, clear all counters and overflow, then go to LOAD_K.
REQ-018 tpu_rst SHALL be 0 in every state except CLR.
REQ-019 LOAD_K outputs SHALL be: in_ready=1, tpu_write_mode=1, tpu_insert_kernal=1, tpu_write=tpu_ready=in_valid, tpu_data_in=in_data (combinational).
REQ-020 LOAD_K SHALL count accepted words (in_valid&in_ready) and go to LOAD_M on the CONV_DIM*CONV_DIM-th word.
REQ-021 LOAD_M outputs SHALL be as in LOAD_K except tpu_insert_kernal=0 and tpu_ready=0.
REQ-022 LOAD_M SHALL go to COMPUTE on the MATRIX_DIM*MATRIX_DIM-th accepted word.
REQ-023 In every state other than LOAD_K and LOAD_M, in_ready SHALL be 0 and tpu_write SHALL be 0.
REQ-024 In COMPUTE, tpu_write_mode SHALL be 0, tpu_insert_kernal SHALL be 0 and tpu_ready SHALL be 1.
REQ-025 In COMPUTE, each cycle with tpu_done=1 SHALL push tpu_data_out into the result FIFO and increment the result counter.
REQ-026 COMPUTE SHALL go to FIN when the result counter reaches MATRIX_DIM*MATRIX_DIM.
REQ-027 tpu_done SHALL be ignored outside COMPUTE.
REQ-028 If the FIFO is full when a tpu_done push occurs, the result SHALL be dropped and still counted, and overflow SHALL set sticky until the next CLR.
REQ-029 If a pop and a push occur in the same cycle with the FIFO full, both SHALL succeed and no overflow SHALL be flagged.
REQ-030 The result FIFO SHALL be first-in first-out: out_valid = not empty, out_data = head entry, pop on out_valid&out_ready.
REQ-031 Pushes SHALL appear on out_valid no earlier than the cycle after the push (zero-latency bypass forbidden).
REQ-032 FIN SHALL hold until the FIFO is empty, then pulse frame_done=1 for 1 cycle and return to IDLE.
REQ-033 busy SHALL be 1 in every state except IDLE.
REQ-034 All counters SHALL be sized $clog2(N)+1 bits and SHALL never wrap within a frame.
REQ-035 The word counter SHALL reset to 0 on entering LOAD_M.

Reset
REQ-036 On rst_n=0, the FSM SHALL enter IDLE asynchronously and the FIFO and all counters SHALL clear.
REQ-037 During and after reset: outputs busy, frame_done, overflow, out_valid, in_ready, tpu_write and tpu_rst SHALL be 0.
REQ-038 During and after reset: outputs tpu_write_mode and tpu_insert_kernal SHALL be 0, and tpu_data_in SHALL be 0.
REQ-039 Reset mid-frame SHALL discard all queued results with no frame_done.
REQ-040 Deassertion of rst_n SHALL be synchronized internally (2-flop) before leaving IDLE.

Verification (MATRIX_DIM=4, CONV_DIM=3, DATA_WIDTH=8)
REQ-041 start, then 9 kernel words then 16 matrix words with in_valid always 1 -> tpu_write high for exactly 25 cycles, tpu_insert_kernal high for the first 9, COMPUTE entered the cycle after the 25th word.
REQ-042 Engine model issues 16 tpu_done pulses with data 0x01..0x10, out_ready=1 -> out_data sequence 0x01..0x10, frame_done once, overflow=0, busy then 0.
REQ-043 in_valid toggled 1/0 every cycle during load -> only accepted words counted; tpu_write mirrors in_valid; 25 writes total.
REQ-044 out_ready=0 and 6 tpu_done pulses on consecutive cycles -> 4 entries held (0x01..0x04), overflow=1, FIN waits until drained.
REQ-045 rst_n low during LOAD_M after 5 matrix words -> state IDLE, out_valid=0, no frame_done; next start reloads from kernel word 0.
REQ-046 start pulsed during COMPUTE and tpu_done pulsed in IDLE -> both ignored: no state change, no FIFO push.
